// File: rtl/ball_engine.sv
// ball_engine: per-frame ball physics for the VGA pong display.
// The ball advances one step per frame tick, bounces off walls and paddles,
// and scores when it reaches a side wall inside the goal opening.
module ball_engine #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int X_INIT    = 320,
   parameter int Y_INIT    = 240,
   parameter int BALL_HW   = 10,
   parameter int BALL_HH   = 15,
   parameter int GOAL_TOP  = 200,
   parameter int GOAL_BOT  = 280,
   parameter int STEP      = 1,
   parameter int SERVE_FR  = 60,
   parameter int WIN_SCORE = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_end,
   input  logic [9:0] p1_left,
   input  logic [9:0] p1_right,
   input  logic [8:0] p1_top,
   input  logic [8:0] p1_bottom,
   input  logic [9:0] p2_left,
   input  logic [9:0] p2_right,
   input  logic [8:0] p2_top,
   input  logic [8:0] p2_bottom,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic [2:0] winner,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       match_over
);

   typedef enum logic [1:0] {SERVE, PLAY, SCORED, OVER} state_t;

   localparam int CW = $clog2(SERVE_FR + 1);

   localparam logic signed [11:0] STEP_S  = 12'(STEP);
   localparam logic signed [11:0] HW_S    = 12'(BALL_HW);
   localparam logic signed [11:0] HH_S    = 12'(BALL_HH);
   localparam logic signed [11:0] XMAX_S  = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] YMAX_S  = 12'(SCREEN_H - 1);
   localparam logic signed [11:0] GTOP_S  = 12'(GOAL_TOP);
   localparam logic signed [11:0] GBOT_S  = 12'(GOAL_BOT);
   localparam logic [CW-1:0]      SERVE_LAST = CW'(SERVE_FR - 1);
   localparam logic [3:0]         WIN4    = 4'(WIN_SCORE);

   state_t          state;
   logic [CW-1:0]   frame_cnt;
   logic            frame_prev;
   logic            dx_neg;
   logic            dy_neg;

   logic            tick;
   logic signed [11:0] cx, cy, nx, ny;
   logic signed [11:0] p1_l, p1_r, p1_t, p1_b;
   logic signed [11:0] p2_l, p2_r, p2_t, p2_b;
   logic            in_band;
   logic            left_edge, right_edge;
   logic            hit_p1, hit_p2;
   logic            y_wall;
   logic [3:0]      score_p1_inc, score_p2_inc;

   assign tick = frame_end & ~frame_prev;

   // Candidate position is computed in wide signed arithmetic so edges never wrap.
   assign cx = $signed({2'b00, ball_x});
   assign cy = $signed({3'b000, ball_y});
   assign nx = dx_neg ? (cx - STEP_S) : (cx + STEP_S);
   assign ny = dy_neg ? (cy - STEP_S) : (cy + STEP_S);

   assign p1_l = $signed({2'b00, p1_left});
   assign p1_r = $signed({2'b00, p1_right});
   assign p1_t = $signed({3'b000, p1_top});
   assign p1_b = $signed({3'b000, p1_bottom});
   assign p2_l = $signed({2'b00, p2_left});
   assign p2_r = $signed({2'b00, p2_right});
   assign p2_t = $signed({3'b000, p2_top});
   assign p2_b = $signed({3'b000, p2_bottom});

   assign in_band    = (cy > GTOP_S) && (cy < GBOT_S);
   assign left_edge  = (nx - HW_S) <= 12'sd0;
   assign right_edge = (nx + HW_S) >= XMAX_S;

   // A paddle is hit when the ball box at the next x touches or overlaps it.
   assign hit_p1 = ((nx + HW_S) >= p1_l) && ((nx - HW_S) <= p1_r) &&
                   ((cy + HH_S) >= p1_t) && ((cy - HH_S) <= p1_b);
   assign hit_p2 = ((nx + HW_S) >= p2_l) && ((nx - HW_S) <= p2_r) &&
                   ((cy + HH_S) >= p2_t) && ((cy - HH_S) <= p2_b);

   assign y_wall = ((ny - HH_S) <= 12'sd0) || ((ny + HH_S) >= YMAX_S);

   assign score_p1_inc = (score_p1 == WIN4) ? WIN4 : (score_p1 + 4'd1);
   assign score_p2_inc = (score_p2 == WIN4) ? WIN4 : (score_p2 + 4'd1);

   // Match FSM and ball state; everything except the edge detector moves only on a frame tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= SERVE;
         frame_cnt  <= '0;
         frame_prev <= 1'b0;
         dx_neg     <= 1'b0;
         dy_neg     <= 1'b0;
         ball_x     <= 10'(X_INIT);
         ball_y     <= 9'(Y_INIT);
         winner     <= 3'd0;
         score_p1   <= 4'd0;
         score_p2   <= 4'd0;
         match_over <= 1'b0;
      end else begin
         frame_prev <= frame_end;
         if (tick) begin
            case (state)
               SERVE: begin
                  if (frame_cnt == SERVE_LAST) begin
                     frame_cnt <= '0;
                     state     <= PLAY;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
               PLAY: begin
                  if (left_edge && in_band) begin
                     score_p2 <= score_p2_inc;
                     winner   <= 3'd2;
                     dx_neg   <= 1'b0;
                     state    <= SCORED;
                  end else if (right_edge && in_band) begin
                     score_p1 <= score_p1_inc;
                     winner   <= 3'd1;
                     dx_neg   <= 1'b1;
                     state    <= SCORED;
                  end else begin
                     if (hit_p1 || hit_p2 || left_edge || right_edge) begin
                        dx_neg <= ~dx_neg;
                     end else begin
                        ball_x <= nx[9:0];
                     end
                     if (y_wall) begin
                        dy_neg <= ~dy_neg;
                     end else begin
                        ball_y <= ny[8:0];
                     end
                  end
               end
               SCORED: begin
                  ball_x <= 10'(X_INIT);
                  ball_y <= 9'(Y_INIT);
                  if ((score_p1 == WIN4) || (score_p2 == WIN4)) begin
                     match_over <= 1'b1;
                     state      <= OVER;
                  end else begin
                     state <= SERVE;
                  end
               end
               OVER: begin
                  state <= OVER;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: randomized scoreboard bench for ball_engine.
// Stimulus steps a behavioural model per frame and queues its outputs;
// an independent monitor spots frame ticks and compares the DUT against the queue.
module tb_ball_engine;

   typedef struct {
      int x, y, dx, dy, s1, s2, win, mode, cnt, over;
   } model_t;

   typedef struct {
      int l, r, t, b;
   } box_t;

   // model modes: 0 serve, 1 play, 2 scored, 3 over
   logic       clk = 1'b0;
   logic       reset;
   logic       frame_end;
   logic [9:0] p1_left, p1_right, p2_left, p2_right;
   logic [8:0] p1_top, p1_bottom, p2_top, p2_bottom;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [2:0] winner;
   logic [3:0] score_p1, score_p2;
   logic       match_over;

   int     checks = 0;
   int     passes = 0;
   model_t mdl;
   model_t curExp;
   model_t expQ[$];
   bit     mPrev = 1'b0;

   ball_engine dut (
      .clk(clk), .reset(reset), .frame_end(frame_end),
      .p1_left(p1_left), .p1_right(p1_right), .p1_top(p1_top), .p1_bottom(p1_bottom),
      .p2_left(p2_left), .p2_right(p2_right), .p2_top(p2_top), .p2_bottom(p2_bottom),
      .ball_x(ball_x), .ball_y(ball_y), .winner(winner),
      .score_p1(score_p1), .score_p2(score_p2), .match_over(match_over)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   function automatic model_t resetModel();
      model_t m;
      m.x = 320; m.y = 240; m.dx = 1; m.dy = 1;
      m.s1 = 0; m.s2 = 0; m.win = 0; m.mode = 0; m.cnt = 0; m.over = 0;
      return m;
   endfunction

   function automatic bit touches(box_t p, int nx, int y);
      return (nx + 10 >= p.l) && (nx - 10 <= p.r) && (y + 15 >= p.t) && (y - 15 <= p.b);
   endfunction

   // One frame of game rules applied to the abstract state
   function automatic model_t stepModel(model_t m, box_t a, box_t b);
      int nx, ny;
      bit band;
      case (m.mode)
         0: begin
            m.cnt++;
            if (m.cnt == 60) begin
               m.mode = 1;
               m.cnt = 0;
            end
         end
         1: begin
            nx = m.x + m.dx;
            ny = m.y + m.dy;
            band = (m.y > 200) && (m.y < 280);
            if (nx - 10 <= 0 && band) begin
               m.s2 = (m.s2 < 9) ? m.s2 + 1 : 9;
               m.win = 2; m.dx = 1; m.mode = 2;
            end else if (nx + 10 >= 639 && band) begin
               m.s1 = (m.s1 < 9) ? m.s1 + 1 : 9;
               m.win = 1; m.dx = -1; m.mode = 2;
            end else begin
               if (touches(a, nx, m.y) || touches(b, nx, m.y) || nx - 10 <= 0 || nx + 10 >= 639)
                  m.dx = -m.dx;
               else
                  m.x = nx;
               if (ny - 15 <= 0 || ny + 15 >= 479)
                  m.dy = -m.dy;
               else
                  m.y = ny;
            end
         end
         2: begin
            m.x = 320; m.y = 240;
            if (m.s1 == 9 || m.s2 == 9) begin
               m.mode = 3;
               m.over = 1;
            end else begin
               m.mode = 0;
            end
         end
         default: ;
      endcase
      return m;
   endfunction

   // Which player would score if the ball flew free from here (0 = it bounces off a side first)
   function automatic int lookahead(model_t m);
      box_t   none;
      model_t s;
      int     startDx;
      none = '{0, 0, 0, 0};
      if (m.mode != 1) return 0;
      s = m;
      startDx = m.dx;
      for (int i = 0; i < 800; i++) begin
         s = stepModel(s, none, none);
         if (s.mode == 2) return s.win;
         if (s.dx != startDx) return 0;
      end
      return 0;
   endfunction

   function automatic int clampI(int v, int lo, int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic box_t randBox(model_t m);
      box_t p;
      p.l = clampI(m.x - 30 + int'($urandom_range(0, 60)), 0, 600);
      p.r = p.l + int'($urandom_range(0, 40));
      p.t = clampI(m.y - 40 + int'($urandom_range(0, 80)), 0, 400);
      p.b = p.t + int'($urandom_range(0, 60));
      return p;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   task automatic checkAll(input string tag, input model_t e);
      checkOutput({tag, "_x"}, int'(ball_x), e.x);
      checkOutput({tag, "_y"}, int'(ball_y), e.y);
      checkOutput({tag, "_winner"}, int'(winner), e.win);
      checkOutput({tag, "_score_p1"}, int'(score_p1), e.s1);
      checkOutput({tag, "_score_p2"}, int'(score_p2), e.s2);
      checkOutput({tag, "_match_over"}, int'(match_over), e.over);
   endtask

   // One frame: present paddles, raise frame_end, queue the model's answer, scramble paddles mid-frame
   task automatic applyStimulus(input int hiLen, input box_t a, input box_t b);
      @(negedge clk);
      p1_left = 10'(a.l); p1_right = 10'(a.r); p1_top = 9'(a.t); p1_bottom = 9'(a.b);
      p2_left = 10'(b.l); p2_right = 10'(b.r); p2_top = 9'(b.t); p2_bottom = 9'(b.b);
      frame_end = 1'b1;
      mdl = stepModel(mdl, a, b);
      expQ.push_back(mdl);
      @(negedge clk);
      p1_left = 10'($urandom_range(0, 1023)); p1_right = 10'($urandom_range(0, 1023));
      p1_top = 9'($urandom_range(0, 511)); p1_bottom = 9'($urandom_range(0, 511));
      p2_left = 10'($urandom_range(0, 1023)); p2_right = 10'($urandom_range(0, 1023));
      p2_top = 9'($urandom_range(0, 511)); p2_bottom = 9'($urandom_range(0, 511));
      repeat (hiLen - 1) @(negedge clk);
      frame_end = 1'b0;
   endtask

   // Monitor: detect ticks independently, pop the expected frame on each, otherwise demand stable outputs
   always @(posedge clk) begin
      bit tk;
      tk = reset && frame_end && !mPrev;
      mPrev = reset ? frame_end : 1'b0;
      #1;
      if (!reset) begin
         curExp = resetModel();
      end else if (tk) begin
         if (expQ.size() == 0) begin
            checkOutput("tick_without_expectation", 1, 0);
         end else begin
            curExp = expQ.pop_front();
            checkAll("tick", curExp);
         end
      end else begin
         checkAll("hold", curExp);
      end
   end

   // Directed phases wrapped around randomized play and model-steered goal scoring
   initial begin
      box_t   none, freeze, pb;
      int     guard;
      none   = '{0, 0, 0, 0};
      freeze = '{0, 639, 0, 479};
      curExp = resetModel();
      mdl    = resetModel();
      reset = 1'b0;
      frame_end = 1'b0;
      p1_left = '0; p1_right = '0; p1_top = '0; p1_bottom = '0;
      p2_left = '0; p2_right = '0; p2_top = '0; p2_bottom = '0;

      repeat (3) @(negedge clk);
      checkAll("in_reset", resetModel());
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checkAll("idle_after_reset", resetModel());

      applyStimulus(1000, none, none);
      for (int i = 0; i < 59; i++) applyStimulus(int'($urandom_range(1, 3)), none, none);
      checkOutput("serve_hold_x", int'(ball_x), 320);
      checkOutput("serve_hold_y", int'(ball_y), 240);
      applyStimulus(1, none, none);
      checkOutput("first_move_x", int'(ball_x), 321);
      checkOutput("first_move_y", int'(ball_y), 241);

      pb = '{332, 382, 207, 273};
      applyStimulus(2, none, pb);
      checkOutput("paddle_hold_x", int'(ball_x), 321);
      checkOutput("paddle_y_moves", int'(ball_y), 242);
      applyStimulus(1, none, none);
      checkOutput("paddle_rebound_x", int'(ball_x), 320);

      for (int i = 0; i < 300; i++)
         applyStimulus(int'($urandom_range(1, 3)), randBox(mdl), randBox(mdl));

      guard = 0;
      while (!mdl.over && guard < 16000) begin
         int target;
         target = (mdl.s2 == 0) ? 2 : 1;
         if (mdl.mode == 1 && lookahead(mdl) != target)
            applyStimulus(int'($urandom_range(1, 3)), freeze, none);
         else
            applyStimulus(int'($urandom_range(1, 3)), none, none);
         guard++;
      end
      checkOutput("match_over_reached", int'(match_over), 1);
      checkOutput("final_score_p1", int'(score_p1), 9);

      for (int i = 0; i < 10; i++)
         applyStimulus(int'($urandom_range(1, 3)), randBox(mdl), randBox(mdl));
      checkOutput("over_frozen_x", int'(ball_x), 320);
      checkOutput("over_frozen_y", int'(ball_y), 240);

      reset = 1'b0;
      mdl = resetModel();
      #1;
      checkAll("reset_from_over", resetModel());
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 80; i++)
         applyStimulus(int'($urandom_range(1, 3)), randBox(mdl), randBox(mdl));
      reset = 1'b0;
      mdl = resetModel();
      #1;
      checkAll("reset_mid_play", resetModel());
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1, none, none);
      checkOutput("restart_serve_x", int'(ball_x), 320);
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
